stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl.sv | 153 +++++++++++++++
 tb/tb_stack_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// Stack controller: keeps the top-of-stack element in a register and spills
// the elements beneath it into an external synchronous memory.
//
// Parameters
//   ADDR_WIDTH    address width of the attached stack memory
//   DATA_WIDTH    stack element width
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   op_valid, op            operation request (00 PUSH, 01 POP, 10 REPLACE, 11 no-op)
//   push_data               operand for PUSH and REPLACE
//   err_clear               clears the sticky error flags
//   op_ready                controller can accept an operation (low during POP_WAIT)
//   tos, depth              registered top of stack and element count (tos included)
//   empty, full             depth == 0 / depth == 2^ADDR_WIDTH + 1
//   err_overflow/underflow  sticky error flags
//   mem_addr, mem_in,       synchronous memory port; mem_out is valid one cycle
//   mem_wen, mem_out        after mem_addr is presented
module stack_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  err_clear,
  output logic                  op_ready,
  output logic [DATA_WIDTH-1:0] tos,
  output logic [ADDR_WIDTH:0]   depth,
  output logic                  empty,
  output logic                  full,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_in,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  localparam int unsigned DepthW = ADDR_WIDTH + 1;
  // Memory holds 2^ADDR_WIDTH entries; the tos register adds one more.
  localparam logic [DepthW-1:0] CapDepth = DepthW'((1 << ADDR_WIDTH) + 1);
  localparam logic [DepthW-1:0] DepthOne = DepthW'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrTwo = ADDR_WIDTH'(2);

  localparam logic [1:0] OpPush    = 2'b00;
  localparam logic [1:0] OpPop     = 2'b01;
  localparam logic [1:0] OpReplace = 2'b10;

  typedef enum logic {StIdle, StPopWait} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tos_q, tos_d;
  logic [DepthW-1:0]     depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  is_empty, is_full;
  logic [ADDR_WIDTH-1:0] depth_lo;

  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == CapDepth);
  // Address arithmetic wraps modulo 2^ADDR_WIDTH, which gives the right slot
  // even when depth itself needs the extra top bit.
  assign depth_lo = depth_q[ADDR_WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    tos_d    = tos_q;
    depth_d  = depth_q;
    // A new error on the same edge wins over err_clear.
    ovf_d    = ovf_q & ~err_clear;
    unf_d    = unf_q & ~err_clear;
    mem_wen  = 1'b0;
    mem_addr = '0;
    mem_in   = '0;

    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          case (op)
            OpPush: begin
              if (is_full) begin
                ovf_d = 1'b1;
              end else if (is_empty) begin
                tos_d   = push_data;
                depth_d = DepthOne;
              end else begin
                // Spill current tos into the slot directly beneath the new one.
                mem_wen  = 1'b1;
                mem_addr = depth_lo - AddrOne;
                mem_in   = tos_q;
                tos_d    = push_data;
                depth_d  = depth_q + DepthOne;
              end
            end
            OpPop: begin
              if (is_empty) begin
                unf_d = 1'b1;
              end else if (depth_q == DepthOne) begin
                tos_d   = '0;
                depth_d = '0;
              end else begin
                mem_addr = depth_lo - AddrTwo;
                state_d  = StPopWait;
              end
            end
            OpReplace: begin
              if (is_empty) begin
                unf_d = 1'b1;
              end else begin
                tos_d = push_data;
              end
            end
            default: ;
          endcase
        end
      end
      StPopWait: begin
        tos_d   = mem_out;
        depth_d = depth_q - DepthOne;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tos_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tos_q   <= tos_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign op_ready      = (state_q == StIdle);
  assign tos           = tos_q;
  assign depth         = depth_q;
  assign empty         = is_empty;
  assign full          = is_full;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with ADDR_WIDTH=2, DATA_WIDTH=8 (capacity 5).
// Inputs change on the falling edge; registered outputs are sampled 1ns after
// the rising edge and combinational memory-port outputs 1ns after the inputs.
module tb_stack_ctrl;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst_n;
  logic          op_valid;
  logic [1:0]    op;
  logic [DW-1:0] push_data;
  logic          err_clear;
  logic          op_ready;
  logic [DW-1:0] tos;
  logic [AW:0]   depth;
  logic          empty;
  logic          full;
  logic          err_overflow;
  logic          err_underflow;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_in;
  logic          mem_wen;
  logic [DW-1:0] mem_out;

  logic [DW-1:0] mem [4];

  int checks = 0;
  int errors = 0;

  stack_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_valid     (op_valid),
    .op           (op),
    .push_data    (push_data),
    .err_clear    (err_clear),
    .op_ready     (op_ready),
    .tos          (tos),
    .depth        (depth),
    .empty        (empty),
    .full         (full),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow),
    .mem_addr     (mem_addr),
    .mem_in       (mem_in),
    .mem_wen      (mem_wen),
    .mem_out      (mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: registered read data.
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_in;
    mem_out <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [DW-1:0] d,
                       input logic clr);
    @(negedge clk);
    op_valid  = v;
    op        = o;
    push_data = d;
    err_clear = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tos"}, 32'(tos), 32'h0);
    chk({tag, "_depth"}, 32'(depth), 32'h0);
    chk({tag, "_empty"}, 32'(empty), 32'h1);
    chk({tag, "_full"}, 32'(full), 32'h0);
    chk({tag, "_ovf"}, 32'(err_overflow), 32'h0);
    chk({tag, "_unf"}, 32'(err_underflow), 32'h0);
    chk({tag, "_ready"}, 32'(op_ready), 32'h1);
    chk({tag, "_wen"}, 32'(mem_wen), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    op_valid  = 1'b0;
    err_clear = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    op_valid  = 1'b0;
    op        = 2'b00;
    push_data = '0;
    err_clear = 1'b0;

    // Reset asserted mid-cycle takes effect without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back PUSH 0x11, 0x22, 0x33.
    drive(1'b1, 2'b00, 8'h11, 1'b0);
    chk("push1_wen", 32'(mem_wen), 32'h0);
    tick();
    chk("push1_tos", 32'(tos), 32'h11);
    chk("push1_depth", 32'(depth), 32'h1);
    drive(1'b1, 2'b00, 8'h22, 1'b0);
    chk("push2_wen", 32'(mem_wen), 32'h1);
    chk("push2_addr", 32'(mem_addr), 32'h0);
    chk("push2_in", 32'(mem_in), 32'h11);
    tick();
    chk("push2_mem0", 32'(mem[0]), 32'h11);
    drive(1'b1, 2'b00, 8'h33, 1'b0);
    chk("push3_wen", 32'(mem_wen), 32'h1);
    chk("push3_addr", 32'(mem_addr), 32'h1);
    chk("push3_in", 32'(mem_in), 32'h22);
    chk("push3_ready", 32'(op_ready), 32'h1);
    tick();
    chk("push3_mem1", 32'(mem[1]), 32'h22);
    chk("push3_tos", 32'(tos), 32'h33);
    chk("push3_depth", 32'(depth), 32'h3);
    chk("push3_ready_after", 32'(op_ready), 32'h1);

    // POP held valid: one accepted every two cycles.
    drive(1'b1, 2'b01, 8'h00, 1'b0);
    chk("pop1_addr", 32'(mem_addr), 32'h1);
    chk("pop1_wen", 32'(mem_wen), 32'h0);
    tick();
    chk("pop1_wait_ready", 32'(op_ready), 32'h0);
    chk("pop1_wait_depth", 32'(depth), 32'h3);
    tick();
    chk("pop1_tos", 32'(tos), 32'h22);
    chk("pop1_depth", 32'(depth), 32'h2);
    chk("pop1_ready", 32'(op_ready), 32'h1);
    chk("pop2_addr", 32'(mem_addr), 32'h0);
    tick();
    chk("pop2_wait_ready", 32'(op_ready), 32'h0);
    tick();
    chk("pop2_tos", 32'(tos), 32'h11);
    chk("pop2_depth", 32'(depth), 32'h1);
    tick();
    chk("pop3_tos", 32'(tos), 32'h0);
    chk("pop3_depth", 32'(depth), 32'h0);
    chk("pop3_empty", 32'(empty), 32'h1);
    chk("pop3_ready", 32'(op_ready), 32'h1);

    // Fill to capacity, then overflow.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 2'b00, 8'(8'hA0 + i), 1'b0);
      tick();
    end
    chk("fill_depth", 32'(depth), 32'h5);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_tos", 32'(tos), 32'hA5);
    chk("fill_mem3", 32'(mem[3]), 32'hA4);
    drive(1'b1, 2'b00, 8'h99, 1'b0);
    chk("ovf_wen", 32'(mem_wen), 32'h0);
    tick();
    chk("ovf_flag", 32'(err_overflow), 32'h1);
    chk("ovf_tos", 32'(tos), 32'hA5);
    chk("ovf_depth", 32'(depth), 32'h5);
    chk("ovf_mem3", 32'(mem[3]), 32'hA4);
    chk("ovf_ready", 32'(op_ready), 32'h1);
    // Flag stays set while idle.
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    tick();
    chk("ovf_sticky", 32'(err_overflow), 32'h1);
    // New error and err_clear on the same edge: flag remains set.
    drive(1'b1, 2'b00, 8'h99, 1'b1);
    tick();
    chk("ovf_clr_collide", 32'(err_overflow), 32'h1);
    drive(1'b0, 2'b00, 8'h00, 1'b1);
    tick();
    chk("ovf_cleared", 32'(err_overflow), 32'h0);

    // Underflow on an empty stack.
    do_reset();
    drive(1'b1, 2'b01, 8'h00, 1'b0);
    chk("unf_pop_addr", 32'(mem_addr), 32'h0);
    tick();
    chk("unf_pop_flag", 32'(err_underflow), 32'h1);
    chk("unf_pop_depth", 32'(depth), 32'h0);
    chk("unf_pop_tos", 32'(tos), 32'h0);
    chk("unf_pop_ready", 32'(op_ready), 32'h1);
    drive(1'b0, 2'b00, 8'h00, 1'b1);
    tick();
    chk("unf_cleared", 32'(err_underflow), 32'h0);
    drive(1'b1, 2'b10, 8'h44, 1'b0);
    tick();
    chk("unf_rep_flag", 32'(err_underflow), 32'h1);
    chk("unf_rep_depth", 32'(depth), 32'h0);
    chk("unf_rep_tos", 32'(tos), 32'h0);
    drive(1'b0, 2'b00, 8'h00, 1'b1);
    tick();

    // REPLACE at depth 2, then reserved op as no-op.
    drive(1'b1, 2'b00, 8'h55, 1'b0);
    tick();
    drive(1'b1, 2'b00, 8'h66, 1'b0);
    tick();
    drive(1'b1, 2'b10, 8'h44, 1'b0);
    chk("rep_wen", 32'(mem_wen), 32'h0);
    tick();
    chk("rep_tos", 32'(tos), 32'h44);
    chk("rep_depth", 32'(depth), 32'h2);
    chk("rep_unf", 32'(err_underflow), 32'h0);
    drive(1'b1, 2'b11, 8'h77, 1'b0);
    chk("nop_wen", 32'(mem_wen), 32'h0);
    tick();
    chk("nop_tos", 32'(tos), 32'h44);
    chk("nop_depth", 32'(depth), 32'h2);
    chk("nop_ready", 32'(op_ready), 32'h1);

    // op ignored when op_valid is low.
    drive(1'b0, 2'b00, 8'h12, 1'b0);
    tick();
    chk("novalid_tos", 32'(tos), 32'h44);

    // Reset during POP_WAIT.
    drive(1'b1, 2'b01, 8'h00, 1'b0);
    tick();
    chk("rstpw_wait_ready", 32'(op_ready), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rstpw");
    tick();
    chk("rstpw_tos_hold", 32'(tos), 32'h0);
    chk("rstpw_depth_hold", 32'(depth), 32'h0);
    @(negedge clk);
    op_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    chk("rstpw_after_ready", 32'(op_ready), 32'h1);
    chk("rstpw_after_depth", 32'(depth), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
